// File: rtl/parking_pkg.sv
// Shared types for the parking gate scheduler: FSM states, service direction, default sizes.
package parking_pkg;
  localparam int NUM_SLOTS_D = 4;
  localparam int SLOT_W_D    = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_OPEN, ST_COMMIT, ST_CLOSE} state_t;
  typedef enum logic {DIR_ENTRY = 1'b0, DIR_EXIT = 1'b1} dir_t;
endpackage

// File: rtl/parking_free_slot_finder.sv
// Combinational priority encoder: lowest-index free slot and the all-full flag.
module parking_free_slot_finder #(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    best_slot,
  output logic                 full
);
  // Scan high to low so the lowest free index is the last one written.
  always_comb begin
    best_slot = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!occupancy[i]) best_slot = SLOT_W'(i);
    end
  end

  assign full = &occupancy;
endmodule

// File: rtl/parking_gate_scheduler.sv
// Shared entry/exit gate sequencer; owns the occupancy map and arbitrates lanes round robin.
module parking_gate_scheduler
  import parking_pkg::*;
#(
  parameter int NUM_SLOTS    = NUM_SLOTS_D,
  parameter int SLOT_W       = SLOT_W_D,
  parameter int PASS_TIMEOUT = 64,
  parameter int CLOSE_GAP    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 entry_req,
  input  logic                 exit_req,
  input  logic [SLOT_W-1:0]    exit_location,
  input  logic                 car_passed,
  output logic                 door_open,
  output logic                 full_light,
  output logic [NUM_SLOTS-1:0] occupancy,
  output logic [SLOT_W-1:0]    best_slot,
  output logic                 grant_entry,
  output logic                 grant_exit,
  output logic [SLOT_W-1:0]    assigned_slot,
  output logic                 exit_reject,
  output logic                 timeout_err,
  output logic                 busy
);
  localparam int TW = $clog2(PASS_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMAX = '1;

  state_t               state, state_n;
  dir_t                 last_dir, last_dir_n;
  logic [TW-1:0]        timer, timer_n, timer_inc;
  logic [NUM_SLOTS-1:0] occ_n;
  logic [SLOT_W-1:0]    slot_n;
  logic                 ge_n, gx_n, rej_n, to_n;
  logic                 entry_ok, exit_ok, exit_bad;

  parking_free_slot_finder #(.NUM_SLOTS(NUM_SLOTS), .SLOT_W(SLOT_W)) u_finder (
    .occupancy (occupancy),
    .best_slot (best_slot),
    .full      (full_light)
  );

  assign timer_inc = (timer == TMAX) ? timer : timer + 1'b1;
  assign entry_ok  = entry_req & ~full_light;
  assign exit_ok   = exit_req & occupancy[exit_location];
  assign exit_bad  = exit_req & ~occupancy[exit_location];
  assign door_open = (state == ST_OPEN) || (state == ST_COMMIT);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      last_dir      <= DIR_EXIT;
      timer         <= '0;
      occupancy     <= '0;
      assigned_slot <= '0;
      grant_entry   <= 1'b0;
      grant_exit    <= 1'b0;
      exit_reject   <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state         <= state_n;
      last_dir      <= last_dir_n;
      timer         <= timer_n;
      occupancy     <= occ_n;
      assigned_slot <= slot_n;
      grant_entry   <= ge_n;
      grant_exit    <= gx_n;
      exit_reject   <= rej_n;
      timeout_err   <= to_n;
    end
  end

  always_comb begin
    state_n    = state;
    last_dir_n = last_dir;
    timer_n    = timer;
    occ_n      = occupancy;
    slot_n     = assigned_slot;
    ge_n       = 1'b0;
    gx_n       = 1'b0;
    rej_n      = 1'b0;
    to_n       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        rej_n = exit_bad;
        // On a tie the direction not served last time goes first.
        if (entry_ok && (!exit_ok || last_dir == DIR_EXIT)) begin
          state_n    = ST_OPEN;
          ge_n       = 1'b1;
          slot_n     = best_slot;
          last_dir_n = DIR_ENTRY;
          timer_n    = '0;
        end else if (exit_ok) begin
          state_n    = ST_OPEN;
          gx_n       = 1'b1;
          slot_n     = exit_location;
          last_dir_n = DIR_EXIT;
          timer_n    = '0;
        end
      end
      ST_OPEN: begin
        timer_n = timer_inc;
        if (car_passed) begin
          state_n = ST_COMMIT;
        end else if (timer == TW'(PASS_TIMEOUT - 1)) begin
          state_n = ST_CLOSE;
          to_n    = 1'b1;
          timer_n = '0;
        end
      end
      ST_COMMIT: begin
        occ_n[assigned_slot] = (last_dir == DIR_ENTRY);
        state_n = ST_CLOSE;
        timer_n = '0;
      end
      ST_CLOSE: begin
        timer_n = timer_inc;
        if (timer == TW'(CLOSE_GAP - 1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_parking_gate_scheduler.sv
// Directed bench for parking_gate_scheduler with a service-timeline reference model.
module tb_parking_gate_scheduler;
  localparam int PT  = 64;
  localparam int GAP = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       entry_req = 1'b0, exit_req = 1'b0, car_passed = 1'b0;
  logic [1:0] exit_location = 2'd0;
  logic       door_open, full_light, grant_entry, grant_exit, exit_reject, timeout_err, busy;
  logic [3:0] occupancy;
  logic [1:0] best_slot, assigned_slot;

  int total = 0;
  int bad = 0;

  parking_gate_scheduler dut (
    .clk(clk), .reset(reset), .entry_req(entry_req), .exit_req(exit_req),
    .exit_location(exit_location), .car_passed(car_passed), .door_open(door_open),
    .full_light(full_light), .occupancy(occupancy), .best_slot(best_slot),
    .grant_entry(grant_entry), .grant_exit(grant_exit), .assigned_slot(assigned_slot),
    .exit_reject(exit_reject), .timeout_err(timeout_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a service is a timeline t=0.. from the grant; the door is open up to
  // one cycle past the pass (commit) or through cycle PT-1, then closed GAP cycles.
  logic [3:0] m_occ;
  logic [1:0] m_slot;
  bit m_busy, m_dir_entry, m_last_entry;
  bit e_ge, e_gx, e_rej, e_to;
  int m_t, m_pass;

  function automatic int free_slot(input logic [3:0] occ);
    for (int i = 0; i < 4; i++) if (!occ[i]) return i;
    return 0;
  endfunction

  function automatic int open_end();
    return (m_pass >= 0) ? m_pass + 1 : PT - 1;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_occ = 0; m_slot = 0; m_busy = 0; m_dir_entry = 0; m_last_entry = 0;
      e_ge = 0; e_gx = 0; e_rej = 0; e_to = 0; m_t = 0; m_pass = -1;
    end else begin
      bit en, ex, pick;
      e_ge = 0; e_gx = 0; e_rej = 0; e_to = 0;
      if (!m_busy) begin
        en = entry_req && (m_occ != 4'hF);
        ex = exit_req && m_occ[exit_location];
        e_rej = exit_req && !m_occ[exit_location];
        pick = (en && ex) ? !m_last_entry : en;
        if (en || ex) begin
          m_busy = 1; m_t = 0; m_pass = -1; m_dir_entry = pick; m_last_entry = pick;
          m_slot = pick ? 2'(free_slot(m_occ)) : exit_location;
          e_ge = pick; e_gx = !pick;
        end
      end else begin
        if (m_pass < 0 && m_t < PT && car_passed) m_pass = m_t;
        if (m_pass >= 0 && m_t == m_pass + 1) m_occ[m_slot] = m_dir_entry;
        if (m_pass < 0 && m_t == PT - 1) e_to = 1;
        if (m_t == open_end() + GAP) m_busy = 0;
        else m_t++;
      end
    end
  end

  always @(negedge clk) begin
    chk("door_open", door_open, int'(m_busy && m_t <= open_end()));
    chk("busy", busy, int'(m_busy));
    chk("occupancy", occupancy, m_occ);
    chk("full_light", full_light, int'(m_occ == 4'hF));
    chk("best_slot", best_slot, free_slot(m_occ));
    chk("assigned_slot", assigned_slot, m_slot);
    chk("grant_entry", grant_entry, int'(e_ge));
    chk("grant_exit", grant_exit, int'(e_gx));
    chk("exit_reject", exit_reject, int'(e_rej));
    chk("timeout_err", timeout_err, int'(e_to));
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    #1 reset = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    step();
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && busy; i++) step();
    chk("idle_wait", busy, 0);
  endtask

  task automatic pass_car(input int dly);
    repeat (dly) step();
    car_passed = 1'b1;
    step();
    car_passed = 1'b0;
  endtask

  task automatic do_entry(input int exp_slot, input int dly);
    entry_req = 1'b1;
    for (int i = 0; i < 20 && !grant_entry; i++) step();
    chk("entry_granted", grant_entry, 1);
    chk("entry_slot", assigned_slot, exp_slot);
    entry_req = 1'b0;
    pass_car(dly);
    wait_idle();
  endtask

  task automatic do_exit(input int loc);
    exit_req = 1'b1; exit_location = 2'(loc);
    for (int i = 0; i < 20 && !grant_exit; i++) step();
    chk("exit_granted", grant_exit, 1);
    chk("exit_slot", assigned_slot, loc);
    exit_req = 1'b0;
    pass_car(1);
    wait_idle();
  endtask

  initial begin
    int cnt, dcnt;
    do_reset();
    chk("reset_occ", occupancy, 0);
    chk("reset_door", door_open, 0);
    chk("reset_busy", busy, 0);

    do_entry(0, 2);
    chk("first_entry_occ", occupancy, 4'b0001);
    do_entry(1, 0);
    do_entry(2, 3);
    do_entry(3, 1);
    chk("fill_occ", occupancy, 4'b1111);
    chk("fill_full", full_light, 1);
    entry_req = 1'b1; cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += int'(grant_entry); end
    entry_req = 1'b0;
    chk("full_no_grant", cnt, 0);

    do_reset();
    do_entry(0, 1); do_entry(1, 1); do_entry(2, 1);
    do_exit(2);
    chk("tie_setup_occ", occupancy, 4'b0011);
    entry_req = 1'b1; exit_req = 1'b1; exit_location = 2'd1;
    for (int i = 0; i < 20 && !grant_entry && !grant_exit; i++) step();
    chk("tie_entry_first", grant_entry, 1);
    chk("tie_entry_slot", assigned_slot, 2);
    entry_req = 1'b0;
    pass_car(1);
    wait_idle();
    for (int i = 0; i < 20 && !grant_exit; i++) step();
    chk("tie_exit_second", grant_exit, 1);
    exit_req = 1'b0;
    pass_car(1);
    wait_idle();
    chk("tie_final_occ", occupancy, 4'b0101);

    do_reset();
    do_entry(0, 1);
    exit_req = 1'b1; exit_location = 2'd2; cnt = 0; dcnt = 0;
    for (int i = 0; i < 3; i++) begin step(); cnt += int'(exit_reject); dcnt += int'(door_open); end
    exit_req = 1'b0; exit_location = 2'd0;
    step();
    chk("reject_count", cnt, 3);
    chk("reject_door", dcnt, 0);
    chk("reject_occ", occupancy, 4'b0001);

    entry_req = 1'b1;
    for (int i = 0; i < 20 && !grant_entry; i++) step();
    entry_req = 1'b0;
    cnt = 0; dcnt = int'(door_open);
    for (int i = 0; i < 80; i++) begin step(); cnt += int'(timeout_err); dcnt += int'(door_open); end
    chk("timeout_pulses", cnt, 1);
    chk("timeout_door_cycles", dcnt, PT);
    chk("timeout_occ", occupancy, 4'b0001);
    chk("timeout_idle", busy, 0);

    entry_req = 1'b1;
    for (int i = 0; i < 20 && !grant_entry; i++) step();
    entry_req = 1'b0;
    step();
    #1 reset = 1'b0;
    #1;
    chk("rst_open_door", door_open, 0);
    chk("rst_open_occ", occupancy, 0);
    chk("rst_open_busy", busy, 0);
    repeat (2) step();
    reset = 1'b1;
    step();
    do_entry(0, 2);
    chk("recover_occ", occupancy, 4'b0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
